harvard_bus_arbiter: RTL and testbench
======================================

Name: harvard_bus_arbiter

Overview:
- Shares one single-ported, wait-stated memory between the Harvard CPU's instruction and data ports.
- Sequences each CPU instruction as an instruction fetch, then an optional data access, then a one-cycle commit.
- Stalls the CPU through its clock_enable input. Halts when the CPU drops active, and flags bus timeouts.
- Sits between mips_cpu_harvard and the shared memory in the system top.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive waitrequest cycles that abort an access with an error.
- COUNT_WIDTH, 32: width of the commit counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_instr_address  in  32  fetch address from CPU
cpu_instr_readdata  out  32  latched instruction to CPU
cpu_data_address  in  32  data address from CPU
cpu_data_read  in  1  CPU data read request
cpu_data_write  in  1  CPU data write request
cpu_data_writedata  in  32  store data from CPU
cpu_data_readdata  out  32  latched load data to CPU
cpu_active  in  1  CPU running flag
cpu_clock_enable  out  1  CPU advance strobe
mem_address  out  32  shared memory address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_writedata  out  32  memory write data
mem_readdata  in  32  memory read data, valid when waitrequest=0
mem_waitrequest  in  1  memory stall
halted  out  1  CPU finished (sticky)
bus_error  out  1  timeout or protocol error (sticky)
commit_count  out  COUNT_WIDTH  instructions committed

Behaviour:
- Reset (reset=0, async): state FETCH. All registered outputs are 0: cpu_instr_readdata, cpu_data_readdata, halted, bus_error, commit_count and the wait counter. mem_read, mem_write and cpu_clock_enable are forced to 0 while reset=0.
- Memory handshake: the request and address are held stable until a rising edge sees mem_waitrequest=0. mem_readdata is sampled on that edge.
- State outputs are combinational decodes of the state:
  - FETCH: mem_address=cpu_instr_address. mem_read=cpu_active.
  - DATA: mem_address=cpu_data_address. mem_read=cpu_data_read. mem_write=cpu_data_write. mem_writedata=cpu_data_writedata.
  - COMMIT: cpu_clock_enable=1. This is the only state where it is 1.
  - HALT and ERROR: no requests.
- FETCH transitions:
  - cpu_active=0: go to HALT and set halted=1. No request is issued.
  - Completion edge: latch mem_readdata into cpu_instr_readdata, then go to DATA.
- DATA transitions (the CPU decodes the latched instruction, so its data strobes are valid here):
  - Neither strobe set: go to COMMIT on the next edge (one dead cycle).
  - cpu_data_read: on completion, latch mem_readdata into cpu_data_readdata, then go to COMMIT.
  - cpu_data_write: on completion, go to COMMIT.
  - Both strobes set: go to ERROR and set bus_error=1. No access is issued.
- COMMIT: exactly one cycle. commit_count increments (wraps modulo 2^COUNT_WIDTH), then go to FETCH.
- Latency: with zero wait states, 3 clocks per load/store and 3 clocks per non-memory instruction. Each wait-state cycle adds 1 clock.
- Timeout:
  - The wait counter increments on each edge where a request is held and mem_waitrequest=1. It clears on completion or on any state change.
  - When the count reaches TIMEOUT_CYCLES, go to ERROR and set bus_error=1. The request drops in the next cycle.
- HALT and ERROR are terminal until reset. In both, cpu_clock_enable=0 and no memory traffic occurs.
- Reset asserted mid-access abandons the transaction immediately. The memory must tolerate a request withdrawn while waitrequest=1.

Decomposition:
- Package harvard_bus_pkg: state enum (FETCH, DATA, COMMIT, HALT, ERROR) and a default TIMEOUT constant.
- One sub-module, bus_timeout_counter: clear, count-enable, limit, and an expired output. Parameterised by TIMEOUT_CYCLES.

Test Plan:
- Zero-wait memory, instruction 0x24020005 at the fetch address, no data strobes: mem_read for 1 cycle, then 1 dead cycle, then cpu_clock_enable=1 on cycle 3. commit_count=1 and cpu_instr_readdata=0x24020005.
- Load with 2 wait states, mem_readdata=0xDEADBEEF: cpu_data_readdata=0xDEADBEEF and cpu_clock_enable pulses on clock 5. mem_address switches from the instruction address to the data address exactly at the DATA entry.
- Store to 0x00001000 with 0x12345678: a single mem_write cycle carrying that address and data, with mem_read=0 throughout DATA.
- mem_waitrequest held at 1 with TIMEOUT_CYCLES=16: after 16 stalled edges bus_error=1, requests drop and cpu_clock_enable stays 0 permanently.
- cpu_active cleared after 4 commits: halted=1, commit_count=4 and no further mem_read. Both data strobes set at once: bus_error=1.
- reset pulsed low mid-fetch with waitrequest=1: mem_read=0 immediately and all outputs are 0. After release, a clean fetch restarts with commit_count=0.

Source files
------------

// File: rtl/harvard_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : harvard_bus_pkg
// Description : Shared types and constants for the Harvard bus arbiter:
//               the arbiter state encoding and the default bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package harvard_bus_pkg;

    // Default number of consecutive stalled edges before an access is aborted.
    localparam int c_default_timeout = 16;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DATA   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_HALT   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/harvard_bus_arbiter_timeout.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_counter
// Description : Counts consecutive stalled bus edges. 'expired' is raised
//               combinationally during the cycle whose edge would be the
//               limit-th stalled edge, so the owner can leave on that edge.
// Ports       : clk, reset (async, active-low), clear, count_en, limit,
//               expired
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter
    import harvard_bus_pkg::*;
#(
    parameter int  TIMEOUT_CYCLES = c_default_timeout,
    localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          count_en,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic [CW-1:0] r_count;
    logic [CW:0]   w_next_count;

    assign w_next_count = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
    assign expired      = count_en && (w_next_count >= {1'b0, limit});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && !expired) begin
            r_count <= w_next_count[CW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/harvard_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : harvard_bus_arbiter
// Description : Shares one single-ported, wait-stated memory between the
//               instruction and data ports of a Harvard CPU. Each instruction
//               is sequenced as FETCH -> DATA -> COMMIT; the CPU advances only
//               on the one-cycle COMMIT strobe. Terminal HALT/ERROR states.
// Ports       : clk, reset (async, active-low)
//               cpu_instr_* / cpu_data_* : CPU side (readdata are latched)
//               cpu_active / cpu_clock_enable : run flag / advance strobe
//               mem_* : shared memory master port (waitrequest handshake)
//               halted, bus_error (sticky), commit_count
// Revision    : 1.0 - initial release
// ============================================================================
module harvard_bus_arbiter
    import harvard_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_default_timeout,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            cpu_instr_address,
    output logic [31:0]            cpu_instr_readdata,
    input  logic [31:0]            cpu_data_address,
    input  logic                   cpu_data_read,
    input  logic                   cpu_data_write,
    input  logic [31:0]            cpu_data_writedata,
    output logic [31:0]            cpu_data_readdata,
    input  logic                   cpu_active,
    output logic                   cpu_clock_enable,
    output logic [31:0]            mem_address,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_writedata,
    input  logic [31:0]            mem_readdata,
    input  logic                   mem_waitrequest,
    output logic                   halted,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] commit_count
);

    localparam int             c_tcw   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tcw-1:0] c_limit = c_tcw'(TIMEOUT_CYCLES);

    state_e                 r_state;
    state_e                 w_next;
    logic [31:0]            r_instr;
    logic [31:0]            r_data;
    logic                   r_halted;
    logic                   r_bus_error;
    logic [COUNT_WIDTH-1:0] r_commit_count;

    logic        w_req_read;
    logic        w_req_write;
    logic        w_ce;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_complete;
    logic        w_count_en;
    logic        w_expired;
    logic        w_clear;

    // Bus request decode. With both data strobes set the access is illegal,
    // so neither request is issued.
    always_comb begin
        w_req_read  = 1'b0;
        w_req_write = 1'b0;
        w_ce        = 1'b0;
        w_addr      = cpu_instr_address;
        w_wdata     = '0;
        case (r_state)
            ST_FETCH: begin
                w_req_read = cpu_active;
            end
            ST_DATA: begin
                w_addr      = cpu_data_address;
                w_wdata     = cpu_data_writedata;
                w_req_read  = cpu_data_read & ~cpu_data_write;
                w_req_write = cpu_data_write & ~cpu_data_read;
            end
            ST_COMMIT: begin
                w_ce = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_count_en = (w_req_read | w_req_write) & mem_waitrequest;
    assign w_complete = (w_req_read | w_req_write) & ~mem_waitrequest;

    // Next-state decode. Completion takes priority over the timeout: an edge
    // with waitrequest low never counts as stalled.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (!cpu_active)     w_next = ST_HALT;
                else if (w_complete) w_next = ST_DATA;
                else if (w_expired)  w_next = ST_ERROR;
            end
            ST_DATA: begin
                if (cpu_data_read && cpu_data_write)        w_next = ST_ERROR;
                else if (!cpu_data_read && !cpu_data_write) w_next = ST_COMMIT;
                else if (w_complete)                        w_next = ST_COMMIT;
                else if (w_expired)                         w_next = ST_ERROR;
            end
            ST_COMMIT: w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            ST_ERROR:  w_next = ST_ERROR;
            default:   w_next = ST_ERROR;
        endcase
    end

    // The wait count belongs to one access: restart it on completion and on
    // every state change.
    assign w_clear = w_complete | (w_next != r_state);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .count_en (w_count_en),
        .limit    (c_limit),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_FETCH;
            r_instr        <= '0;
            r_data         <= '0;
            r_halted       <= 1'b0;
            r_bus_error    <= 1'b0;
            r_commit_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH && w_complete)
                r_instr <= mem_readdata;
            if (r_state == ST_DATA && w_req_read && w_complete)
                r_data <= mem_readdata;
            if (w_next == ST_HALT)
                r_halted <= 1'b1;
            if (w_next == ST_ERROR)
                r_bus_error <= 1'b1;
            if (r_state == ST_COMMIT)
                r_commit_count <= r_commit_count + COUNT_WIDTH'(1);
        end
    end

    // Strobes are gated by reset so an access is withdrawn the moment reset
    // asserts, not at the next edge.
    assign mem_read           = reset & w_req_read;
    assign mem_write          = reset & w_req_write;
    assign cpu_clock_enable   = reset & w_ce;
    assign mem_address        = w_addr;
    assign mem_writedata      = w_wdata;
    assign cpu_instr_readdata = r_instr;
    assign cpu_data_readdata  = r_data;
    assign halted             = r_halted;
    assign bus_error          = r_bus_error;
    assign commit_count       = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_harvard_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_harvard_bus_arbiter
// Description : Self-checking bench. A transaction-level planner turns each
//               instruction (wait states, access kind) into a per-cycle list
//               of stimulus and expected outputs; one executor drives and
//               compares it cycle by cycle. Literal checks pin the planner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_harvard_bus_arbiter;

    localparam int c_timeout = 16;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_active;
    logic        cpu_clock_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        halted;
    logic        bus_error;
    logic [31:0] commit_count;

    harvard_bus_arbiter #(
        .TIMEOUT_CYCLES (c_timeout),
        .COUNT_WIDTH    (32)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .cpu_active         (cpu_active),
        .cpu_clock_enable   (cpu_clock_enable),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_writedata      (mem_writedata),
        .mem_readdata       (mem_readdata),
        .mem_waitrequest    (mem_waitrequest),
        .halted             (halted),
        .bus_error          (bus_error),
        .commit_count       (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        active, dr, dw, wait_r;
        logic [31:0] iaddr, daddr, wdata, rdata;
        logic        e_rd, e_wr, e_ce, e_halt, e_err;
        logic [31:0] e_addr, e_wdata, e_instr, e_data, e_cnt;
    } cyc_t;

    cyc_t q[$];

    int vectors     = 0;
    int miscompares = 0;
    int ce_at;
    int wr_cycles;

    // Planner context: CPU inputs for the instruction being planned, and the
    // architectural values the DUT must be showing.
    logic        cur_active, cur_dr, cur_dw;
    logic [31:0] cur_iaddr, cur_daddr, cur_wdata;
    logic [31:0] m_instr, m_data, m_cnt;
    logic        m_halt, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_instr = '0; m_data = '0; m_cnt = '0; m_halt = 1'b0; m_err = 1'b0;
    endtask

    task automatic push_cyc(input logic w, input logic [31:0] rdat, input logic erd,
                            input logic ewr, input logic ece, input logic [31:0] eaddr);
        cyc_t c;
        c.active = cur_active; c.dr = cur_dr; c.dw = cur_dw;
        c.iaddr  = cur_iaddr;  c.daddr = cur_daddr; c.wdata = cur_wdata;
        c.wait_r = w; c.rdata = rdat;
        c.e_rd = erd; c.e_wr = ewr; c.e_ce = ece; c.e_addr = eaddr; c.e_wdata = cur_wdata;
        c.e_instr = m_instr; c.e_data = m_data; c.e_cnt = m_cnt;
        c.e_halt = m_halt; c.e_err = m_err;
        q.push_back(c);
    endtask

    // kind: 0 = no memory op, 1 = load, 2 = store, 3 = both strobes (illegal).
    // fw/dw: wait-state cycles for the fetch and data accesses.
    task automatic push_instr(input logic [31:0] iaddr, input logic [31:0] instr, input int fw,
                              input int kind, input logic [31:0] daddr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int dw);
        cur_active = 1'b1;
        cur_dr = (kind == 1 || kind == 3);
        cur_dw = (kind == 2 || kind == 3);
        cur_iaddr = iaddr; cur_daddr = daddr; cur_wdata = wdata;
        if (fw >= c_timeout) begin
            for (int i = 0; i < c_timeout; i++) push_cyc(1'b1, 32'hA5A50000 | i, 1'b1, 1'b0, 1'b0, iaddr);
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i <= fw; i++)
            push_cyc(i < fw, (i < fw) ? (32'hA5A50000 | i) : instr, 1'b1, 1'b0, 1'b0, iaddr);
        m_instr = instr;
        if (kind == 0) begin
            push_cyc(1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h0);
        end else if (kind == 3) begin
            push_cyc(1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h0);
            m_err = 1'b1;
            return;
        end else begin
            if (dw >= c_timeout) begin
                for (int i = 0; i < c_timeout; i++)
                    push_cyc(1'b1, 32'hB6B60000 | i, kind == 1, kind == 2, 1'b0, daddr);
                m_err = 1'b1;
                return;
            end
            for (int i = 0; i <= dw; i++)
                push_cyc(i < dw, (i < dw) ? (32'hB6B60000 | i) : rdata, kind == 1, kind == 2, 1'b0, daddr);
            if (kind == 1) m_data = rdata;
        end
        push_cyc(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'h0);
        m_cnt = m_cnt + 1;
    endtask

    task automatic push_halt();
        cur_active = 1'b0; cur_dr = 1'b0; cur_dw = 1'b0;
        push_cyc(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h0);
        m_halt = 1'b1;
    endtask

    task automatic push_idle(input int n);
        cur_active = 1'b1; cur_dr = 1'b0; cur_dw = 1'b0;
        for (int i = 0; i < n; i++) push_cyc(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Entered at a falling edge; drives each planned cycle and compares.
    task automatic run_queue();
        cyc_t c;
        int   n;
        n = 0; ce_at = 0; wr_cycles = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            n++;
            cpu_active = c.active; cpu_data_read = c.dr; cpu_data_write = c.dw;
            cpu_instr_address = c.iaddr; cpu_data_address = c.daddr;
            cpu_data_writedata = c.wdata;
            mem_waitrequest = c.wait_r; mem_readdata = c.rdata;
            #1;
            if (cpu_clock_enable === 1'b1 && ce_at == 0) ce_at = n;
            if (mem_write === 1'b1) wr_cycles++;
            chk("mem_read", mem_read, c.e_rd);
            chk("mem_write", mem_write, c.e_wr);
            chk("cpu_clock_enable", cpu_clock_enable, c.e_ce);
            if (c.e_rd || c.e_wr) chk("mem_address", mem_address, c.e_addr);
            if (c.e_wr) chk("mem_writedata", mem_writedata, c.e_wdata);
            chk("cpu_instr_readdata", cpu_instr_readdata, c.e_instr);
            chk("cpu_data_readdata", cpu_data_readdata, c.e_data);
            chk("commit_count", commit_count, c.e_cnt);
            chk("halted", halted, c.e_halt);
            chk("bus_error", bus_error, c.e_err);
            @(negedge clk);
        end
    endtask

    // Entered at a falling edge; leaves at a falling edge with reset released.
    task automatic do_reset();
        reset = 1'b0;
        cpu_active = 1'b1; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
        mem_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_clock_enable", cpu_clock_enable, 1'b0);
        chk("rst_instr", cpu_instr_readdata, 32'h0);
        chk("rst_data", cpu_data_readdata, 32'h0);
        chk("rst_count", commit_count, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        reset = 1'b0;
        cpu_instr_address = '0; cpu_data_address = '0; cpu_data_writedata = '0;
        cpu_active = 1'b1; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
        mem_readdata = '0; mem_waitrequest = 1'b1;
        model_clear();
        @(negedge clk);
        do_reset();

        // Non-memory instruction, zero waits.
        push_instr(32'h100, 32'h24020005, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        run_queue();
        chk("lit_ce_cycle_nop", ce_at, 3);
        chk("lit_count_1", commit_count, 1);
        chk("lit_instr_nop", cpu_instr_readdata, 32'h24020005);

        // Load with two data wait states.
        push_instr(32'h104, 32'h8C430000, 0, 1, 32'h2000, 32'h0, 32'hDEADBEEF, 2);
        run_queue();
        chk("lit_ce_cycle_load", ce_at, 5);
        chk("lit_load_data", cpu_data_readdata, 32'hDEADBEEF);

        // Store, zero waits: exactly one write cycle.
        push_instr(32'h108, 32'hAC430000, 0, 2, 32'h1000, 32'h12345678, 32'h0, 0);
        run_queue();
        chk("lit_store_write_cycles", wr_cycles, 1);

        // Fetch waits plus the longest data stall that must not time out.
        push_instr(32'h10C, 32'h8C440004, 3, 1, 32'h2004, 32'h0, 32'hCAFEF00D, c_timeout - 1);
        run_queue();
        chk("lit_long_stall_data", cpu_data_readdata, 32'hCAFEF00D);

        // CPU drops active after four commits.
        push_halt();
        push_idle(5);
        run_queue();
        chk("lit_halted", halted, 1'b1);
        chk("lit_halt_count", commit_count, 4);

        // Both data strobes at once.
        do_reset();
        push_instr(32'h200, 32'h00000000, 0, 3, 32'h3000, 32'h0, 32'h0, 0);
        push_idle(4);
        run_queue();
        chk("lit_both_strobes_err", bus_error, 1'b1);

        // Reset asserted in the middle of a stalled fetch.
        do_reset();
        push_instr(32'h300, 32'h8C450008, 0, 1, 32'h2008, 32'h0, 32'h0BADF00D, 0);
        run_queue();
        cpu_active = 1'b1; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
        cpu_instr_address = 32'h304; mem_waitrequest = 1'b1;
        #1;
        chk("lit_midfetch_req", mem_read, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_mem_read", mem_read, 1'b0);
        chk("midrst_clock_enable", cpu_clock_enable, 1'b0);
        chk("midrst_instr", cpu_instr_readdata, 32'h0);
        chk("midrst_data", cpu_data_readdata, 32'h0);
        chk("midrst_count", commit_count, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        push_instr(32'h400, 32'h24030007, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        run_queue();
        chk("lit_restart_count", commit_count, 1);

        // Memory never answers a fetch.
        do_reset();
        push_instr(32'h500, 32'h0, c_timeout, 0, 32'h0, 32'h0, 32'h0, 0);
        push_idle(6);
        run_queue();
        chk("lit_timeout_err", bus_error, 1'b1);
        chk("lit_timeout_count", commit_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
